uart_tx_fifo: RTL

- Transmit half of the UART; the counterpart to the existing receive path (rx, rd_uart, r_data, rx_empty).
- Buffers bytes written by the host in a synchronous FIFO and serialises them onto tx as 8N1 frames.
- Uses 16x oversampling ticks derived from the same run-time dvsr value the receiver uses.
- Sits beside the receiver inside the UART top; tx is shared off-chip.

---
 rtl/uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a byte FIFO, 8N1 framing, 16x ticks.
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
// Ports:
//   clk          rising-edge system clock
//   reset        synchronous active-low reset
//   dvsr         baud divisor, one tick every dvsr+1 clocks
//   wr_uart      write strobe, pushes w_data unless tx_full
//   w_data       byte to transmit
//   tx           serial output, idle high (registered)
//   tx_full      FIFO holds DEPTH entries (registered)
//   tx_empty     FIFO holds no entries (registered)
//   tx_busy      transmitter not idle (registered)
//   tx_done_tick one clock during the last clock of each stop bit
module uart_tx_fifo #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int ADDR_W  = 2,
   parameter int DVSR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              wr_uart,
   input  logic [DBIT-1:0]   w_data,
   output logic              tx,
   output logic              tx_full,
   output logic              tx_empty,
   output logic              tx_busy,
   output logic              tx_done_tick
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = ADDR_W + 1;
   localparam int TW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int BW    = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [DBIT-1:0]   mem_q [DEPTH];
   logic [DBIT-1:0]   mem_d [DEPTH];
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              push, pop;

   state_t            state_q, state_d;
   logic [DVSR_W-1:0] baud_q, baud_d;
   logic              tick;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic [DBIT-1:0]   shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   // FIFO: full blocks pushes even when a pop happens in the same cycle
   always_comb begin
      push   = wr_uart & ~full_q;
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         mem_d[wptr_q] = w_data;
         wptr_d        = wptr_q + ADDR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + ADDR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      full_d  = (cnt_d == CW'(DEPTH));
      empty_d = (cnt_d == '0);
   end

   // Baud generator, parked at zero while idle so every frame
   // starts on a clean tick phase
   always_comb begin
      tick = (state_q != S_IDLE) && (baud_q == dvsr);
      if (state_q == S_IDLE || tick) begin
         baud_d = '0;
      end else begin
         baud_d = baud_q + DVSR_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      pop     = 1'b0;
      done    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               tcnt_d  = '0;
               bcnt_d  = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = ^mem_q[rptr_q];
`endif
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (tcnt_q == TW'(15)) begin
                  tcnt_d  = '0;
                  state_d = S_DATA;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tcnt_q == TW'(15)) begin
                  tcnt_d  = '0;
                  shift_d = shift_q >> 1;
                  if (bcnt_q == BW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     bcnt_d = bcnt_q + BW'(1);
                  end
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               if (tcnt_q == TW'(15)) begin
                  tcnt_d  = '0;
                  state_d = S_STOP;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (tcnt_q == TW'(SB_TICK - 1)) begin
                  tcnt_d  = '0;
                  done    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level follows the next state so tx changes on the same
   // edge as the state register
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = par_q;
`endif
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         state_q <= S_IDLE;
         baud_q  <= '0;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         state_q <= state_d;
         baud_q  <= baud_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = busy_q;
   assign tx_full      = full_q;
   assign tx_empty     = empty_q;
   assign tx_done_tick = done;

endmodule
